// File: rtl/tdm_pkg.sv
// Shared TDM definitions: default sample width / FIFO depth, the
// occupancy-count sizing helper and the per-edge FIFO operation encoding.
package tdm_pkg;

  localparam int TDM_SAMPLE_W   = 4;
  localparam int TDM_FIFO_DEPTH = 8;

  // Bits needed to hold the values 0..n inclusive (an occupancy count).
  function automatic int clog2_plus1(input int n);
    return $clog2(n + 1);
  endfunction

  // What the FIFO accepts on a clock edge: {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/tdm_fifo_mem.sv
// DEPTH x DATA_W sample storage: one synchronous write port and one
// asynchronous, address-indexed read port. Contents are don't-care
// after reset or flush, so the array is never cleared.
module tdm_fifo_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming sample at the write address.
  // NOTE: the array has no reset; occupancy is tracked by pointers and count,
  // so stale contents are never observed and a reset here would only cost area.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tdm_sync_fifo.sv
// Synchronous FIFO buffering TDM samples between the slot sampler and the
// multiplexer output stage. Registered read data with a one-cycle valid
// strobe, occupancy count, full/empty, and sticky overflow/underflow flags.
// en=0 holds the queue flushed.
module tdm_sync_fifo
  import tdm_pkg::*;
#(
  parameter  int DATA_W = TDM_SAMPLE_W,
  parameter  int DEPTH  = TDM_FIFO_DEPTH,
  localparam int CNT_W  = clog2_plus1(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              w_en,
  input  logic [DATA_W-1:0] in1,
  input  logic              r_en,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_acc;
  logic              wr_acc;
  fifo_op_e          op;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);

  // A read frees a slot this edge, so a write into a full FIFO is still
  // accepted when a read is accepted alongside it. No empty bypass.
  assign rd_acc = r_en && !empty;
  assign wr_acc = w_en && (!full || rd_acc);
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  tdm_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (en && wr_acc),
    .waddr (wr_ptr),
    .wdata (in1),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointer, count, output and sticky-flag state; flush on en=0 mirrors reset.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!en) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_next(wr_ptr);
      if (rd_acc) begin
        rd_ptr <= ptr_next(rd_ptr);
        out    <= rd_data;
      end
      out_valid <= rd_acc;

      case (op)
        OP_WR:   count <= count + 1'b1;
        OP_RD:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (w_en && !wr_acc) overflow  <= 1'b1;
      if (r_en && empty)   underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdm_sync_fifo.sv
// Directed bench for tdm_sync_fifo: default geometry (4x8), DEPTH=5 wrap
// streaming, and DATA_W=8/DEPTH=3 against a queue scoreboard.
module tb_tdm_sync_fifo;

  logic clk = 1'b0;
  logic rst;
  logic en;

  // Instance A: DATA_W=4, DEPTH=8
  logic       a_w_en, a_r_en;
  logic [3:0] a_in1, a_out;
  logic       a_out_valid, a_full, a_empty, a_overflow, a_underflow;
  logic [3:0] a_count;

  // Instance B: DATA_W=4, DEPTH=5
  logic       b_w_en, b_r_en;
  logic [3:0] b_in1, b_out;
  logic       b_out_valid, b_full, b_empty, b_overflow, b_underflow;
  logic [2:0] b_count;

  // Instance C: DATA_W=8, DEPTH=3
  logic       c_w_en, c_r_en;
  logic [7:0] c_in1, c_out;
  logic       c_out_valid, c_full, c_empty, c_overflow, c_underflow;
  logic [1:0] c_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdm_sync_fifo u_a (
    .clk(clk), .rst(rst), .en(en), .w_en(a_w_en), .in1(a_in1), .r_en(a_r_en),
    .out(a_out), .out_valid(a_out_valid), .full(a_full), .empty(a_empty),
    .count(a_count), .overflow(a_overflow), .underflow(a_underflow)
  );

  tdm_sync_fifo #(.DATA_W(4), .DEPTH(5)) u_b (
    .clk(clk), .rst(rst), .en(en), .w_en(b_w_en), .in1(b_in1), .r_en(b_r_en),
    .out(b_out), .out_valid(b_out_valid), .full(b_full), .empty(b_empty),
    .count(b_count), .overflow(b_overflow), .underflow(b_underflow)
  );

  tdm_sync_fifo #(.DATA_W(8), .DEPTH(3)) u_c (
    .clk(clk), .rst(rst), .en(en), .w_en(c_w_en), .in1(c_in1), .r_en(c_r_en),
    .out(c_out), .out_valid(c_out_valid), .full(c_full), .empty(c_empty),
    .count(c_count), .overflow(c_overflow), .underflow(c_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] model_q[$];
  logic [7:0] exp_data;
  bit         rw, rr, rd_ok, wr_ok, m_ov, m_un;

  initial begin
    rst = 1'b1; en = 1'b1;
    a_w_en = 0; a_r_en = 0; a_in1 = '0;
    b_w_en = 0; b_r_en = 0; b_in1 = '0;
    c_w_en = 0; c_r_en = 0; c_in1 = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_count", 32'(a_count), 0);
    check("rst_empty", 32'(a_empty), 1);
    check("rst_full",  32'(a_full), 0);
    check("rst_out",   32'(a_out), 0);
    check("rst_valid", 32'(a_out_valid), 0);
    check("rst_ovf",   32'(a_overflow), 0);
    check("rst_unf",   32'(a_underflow), 0);

    // Fill 1..8, then drain in order
    for (int i = 1; i <= 8; i++) begin
      a_w_en = 1; a_in1 = 4'(i);
      tick();
    end
    a_w_en = 0;
    check("fill_count", 32'(a_count), 8);
    check("fill_full",  32'(a_full), 1);
    for (int i = 1; i <= 8; i++) begin
      a_r_en = 1;
      tick();
      check("drain_out",   32'(a_out), 32'(i));
      check("drain_valid", 32'(a_out_valid), 1);
    end
    a_r_en = 0;
    tick();
    check("drain_valid_low", 32'(a_out_valid), 0);
    check("drain_empty",     32'(a_empty), 1);

    // Overflow: write F into a full FIFO, it must never come out
    for (int i = 1; i <= 8; i++) begin
      a_w_en = 1; a_in1 = 4'(i);
      tick();
    end
    a_in1 = 4'hF;
    tick();
    a_w_en = 0;
    check("ovf_flag",  32'(a_overflow), 1);
    check("ovf_count", 32'(a_count), 8);
    for (int i = 1; i <= 8; i++) begin
      a_r_en = 1;
      tick();
      check("ovf_drain_out", 32'(a_out), 32'(i));
    end
    a_r_en = 0;
    tick();
    check("ovf_sticky", 32'(a_overflow), 1);
    check("ovf_empty",  32'(a_empty), 1);
    check("ovf_no_unf", 32'(a_underflow), 0);

    // Underflow alone, then simultaneous write+read on empty
    a_r_en = 1;
    tick();
    check("unf_flag",  32'(a_underflow), 1);
    check("unf_valid", 32'(a_out_valid), 0);
    check("unf_hold",  32'(a_out), 8);
    a_w_en = 1; a_in1 = 4'hA;
    tick();
    check("unf_wr_count", 32'(a_count), 1);
    check("unf_wr_valid", 32'(a_out_valid), 0);
    check("unf_wr_hold",  32'(a_out), 8);
    a_w_en = 0;
    tick();
    check("unf_rd_out",   32'(a_out), 32'hA);
    check("unf_rd_valid", 32'(a_out_valid), 1);
    check("unf_rd_count", 32'(a_count), 0);
    a_r_en = 0;

    // Synchronous flush with en=0; write during flush is discarded
    for (int i = 1; i <= 3; i++) begin
      a_w_en = 1; a_in1 = 4'(i);
      tick();
    end
    en = 0; a_in1 = 4'h7;
    tick();
    check("flush_count", 32'(a_count), 0);
    check("flush_empty", 32'(a_empty), 1);
    check("flush_out",   32'(a_out), 0);
    check("flush_ovf",   32'(a_overflow), 0);
    check("flush_unf",   32'(a_underflow), 0);
    en = 1; a_w_en = 0; a_r_en = 1;
    tick();
    check("flush_absent_valid", 32'(a_out_valid), 0);
    check("flush_absent_unf",   32'(a_underflow), 1);
    check("flush_absent_count", 32'(a_count), 0);
    a_r_en = 0;

    // Asynchronous reset mid-stream with count=5
    for (int i = 1; i <= 6; i++) begin
      a_w_en = 1; a_in1 = 4'(i);
      tick();
    end
    a_w_en = 0; a_r_en = 1;
    tick();
    a_r_en = 0;
    check("pre_rst_count", 32'(a_count), 5);
    check("pre_rst_out",   32'(a_out), 1);
    rst = 1;
    #2;
    check("arst_count", 32'(a_count), 0);
    check("arst_empty", 32'(a_empty), 1);
    check("arst_out",   32'(a_out), 0);
    check("arst_valid", 32'(a_out_valid), 0);
    check("arst_unf",   32'(a_underflow), 0);
    check("arst_ovf",   32'(a_overflow), 0);
    rst = 0;
    tick();

    // DEPTH=5: full simultaneous read/write across several wraps
    for (int k = 0; k < 5; k++) begin
      b_w_en = 1; b_in1 = 4'(k);
      tick();
    end
    check("b_fill_count", 32'(b_count), 5);
    check("b_fill_full",  32'(b_full), 1);
    for (int k = 0; k < 12; k++) begin
      b_w_en = 1; b_r_en = 1; b_in1 = 4'(k + 5);
      tick();
      check("b_wrap_out",   32'(b_out), 32'(k));
      check("b_wrap_valid", 32'(b_out_valid), 1);
      check("b_wrap_count", 32'(b_count), 5);
      check("b_wrap_ovf",   32'(b_overflow), 0);
    end
    b_w_en = 0; b_r_en = 0;

    // DATA_W=8, DEPTH=3: fill, then random traffic against a queue model
    for (int k = 1; k <= 3; k++) begin
      c_w_en = 1; c_in1 = 8'(k * 17);
      model_q.push_back(8'(k * 17));
      tick();
    end
    c_w_en = 0;
    check("c_fill_count", 32'(c_count), 3);
    check("c_fill_full",  32'(c_full), 1);
    m_ov = 0; m_un = 0;
    for (int n = 0; n < 500; n++) begin
      rw = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      c_w_en = rw; c_r_en = rr; c_in1 = 8'($urandom);
      rd_ok = rr && (model_q.size() != 0);
      wr_ok = rw && ((model_q.size() != 3) || rd_ok);
      if (rw && !wr_ok) m_ov = 1;
      if (rr && (model_q.size() == 0)) m_un = 1;
      exp_data = '0;
      if (rd_ok) exp_data = model_q.pop_front();
      if (wr_ok) model_q.push_back(c_in1);
      tick();
      check("c_rand_valid", 32'(c_out_valid), 32'(rd_ok));
      if (rd_ok) check("c_rand_out", 32'(c_out), 32'(exp_data));
      check("c_rand_count", 32'(c_count), 32'(model_q.size()));
    end
    c_w_en = 0; c_r_en = 0;
    check("c_rand_ovf", 32'(c_overflow), 32'(m_ov));
    check("c_rand_unf", 32'(c_underflow), 32'(m_un));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_sync_fifo.md
Name: tdm_sync_fifo

Overview:
Parametrised synchronous FIFO that buffers TDM channel samples between the slot sampler and the multiplexer output stage.
- Generalises the fixed 3-entry, 4-bit shift queue to configurable width and depth.
- Adds explicit full/empty/count status, sticky overflow/underflow error flags, and a registered read-data valid strobe.
- The enable input keeps its existing meaning: when low, the queue is held flushed.

Parameters:
DATA_W, 4, sample width in bits
DEPTH, 8, number of entries; any value >= 2 (power of two not required)
CNT_W, $clog2(DEPTH+1), width of occupancy count; localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  block enable; 0 = synchronous flush/hold-clear
w_en  input  1  write request
in1  input  DATA_W  write data
r_en  input  1  read request
out  output  DATA_W  registered read data
out_valid  output  1  1-cycle strobe: out updated this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  CNT_W  current occupancy
overflow  output  1  sticky: write dropped while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, out=0, out_valid=0, overflow=0, underflow=0.
  - full=0, empty=1.
  - Storage contents are don't-care.
- en=0 at a clock edge (synchronous flush):
  - Same register values as reset.
  - w_en and r_en are ignored.
  - Stored data is discarded.
- All of the following apply only when rst=0 and en=1.
- Accepted write: w_en=1 and (!full or read accepted in the same cycle). mem[wr_ptr]<=in1; wr_ptr advances.
- Accepted read: r_en=1 and !empty. out<=mem[rd_ptr]; rd_ptr advances; out_valid<=1 next cycle.
- Otherwise out_valid<=0 and out holds its last value.
- Read latency: data is visible on out one clock after the accepting edge (registered); no combinational fall-through.
- Pointer wrap: a pointer at DEPTH-1 advances to 0; no reliance on power-of-two masking.
- count update, per edge:
  - +1 on write only; -1 on read only.
  - Unchanged when both or neither are accepted.
  - count never exceeds DEPTH and never goes below 0.
- full and empty are decoded combinationally from count.
- Boundary cases:
  - Full, w_en=1, r_en=0: write dropped; overflow<=1; contents and count unchanged.
  - Full, w_en=1, r_en=1: both accepted; oldest entry is read, new entry written into the freed slot; count stays DEPTH; overflow is not set.
  - Empty, r_en=1, w_en=0: read ignored; underflow<=1; out holds; out_valid=0.
  - Empty, r_en=1, w_en=1: write accepted, read ignored (no bypass); underflow<=1; count becomes 1.
- overflow and underflow stay set until rst or en=0.
- Ordering is strict FIFO; the data read out is the oldest accepted write.

Decomposition:
- Shared package tdm_pkg:
  - TDM_SAMPLE_W (default 4) and TDM_FIFO_DEPTH (default 8), used as this block's parameter defaults.
  - Function clog2_plus1 for count sizing.
- One natural sub-module, tdm_fifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one read port indexed by address.
  - Pointer, count, flag and output registers stay in tdm_sync_fifo.

Test Plan:
- Reset/flush: assert rst mid-stream with count=5 -> immediately count=0, empty=1, out=0, flags=0; repeat with en=0 for one edge -> identical state; writes issued during en=0 are absent afterwards.
- Fill/drain order (DATA_W=4, DEPTH=8): write 1..8 -> full=1 after 8th edge, count=8; then read 8 times -> out sequence 1..8, each out_valid one cycle after its r_en, empty=1 at end.
- Overflow: at full, write 4'hF with r_en=0 -> overflow=1, count=8; drain -> 4'hF never appears; overflow stays 1 until en=0.
- Underflow incl. simultaneous: empty, r_en=1 alone -> underflow=1, out_valid=0; then w_en=1 and r_en=1 with in1=4'hA -> count=1, no out_valid; next read returns 4'hA.
- Full simultaneous + wrap: DEPTH=5, write 5, then 12 cycles of w_en=r_en=1 with incrementing data -> count holds 5, overflow=0, outputs emerge in exact write order across multiple pointer wraps.
- Non-default parameters: DATA_W=8, DEPTH=3 -> CNT_W=2; fill -> count=3, full=1; random w_en/r_en for 500 cycles compared against a scoreboard queue model.
